// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Purpose:
//   Drives an external single-step shifter repeatedly to perform a multi-bit
//   shift.
//
//   A request is accepted while the block is idle. It latches the value, the
//   op and the step count. The accumulator is then presented to the shifter
//   once per clock, and each shifter result is fed back until all steps are
//   done. The final value is published on `result`, and `done` pulses for
//   one cycle.
//
//   Shifter op encoding:
//     00 = pass-through
//     01 = LSL1
//     10 = LSR1
//     11 = ASR1
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous, active-high reset
//   start    in   1      request strobe; sampled only while busy == 0
//   in_data  in   WIDTH  value to shift; latched on an accepted start
//   op       in   2      shift op; latched on an accepted start
//   amount   in   AMT_W  number of single-bit steps; latched on an accepted start
//   sh_in    out  WIDTH  operand to the shifter (the accumulator)
//   sh_ctrl  out  2      shifter control: latched op in SHIFT, 00 otherwise
//   sh_out   in   WIDTH  combinational shifter result for (sh_in, sh_ctrl)
//   busy     out  1      high in SHIFT and DONE
//   done     out  1      one-cycle completion pulse
//   result   out  WIDTH  final value; held until the next completion
// -----------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] sh_in,
    output logic [1:0]       sh_ctrl,
    input  logic [WIDTH-1:0] sh_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [AMT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_result;

    logic w_accept;
    logic w_bypass;
    logic w_last;

    // A request only lands while idle; starts in SHIFT/DONE are dropped.
    assign w_accept = (r_state == S_IDLE) && start;

    // Zero steps or a pass-through op need no shifter cycles at all.
    assign w_bypass = (amount == '0) || (op == 2'b00);

    // The step being taken on this edge is the final one.
    assign w_last = (r_cnt == AMT_W'(1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_bypass ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers: accumulator, step counter, latched op, result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_op     <= 2'b00;
            r_result <= '0;
        end else if (w_accept) begin
            r_acc <= in_data;
            r_op  <= op;
            r_cnt <= amount;
            if (w_bypass) begin
                r_result <= in_data;
            end
        end else if (r_state == S_SHIFT) begin
            r_acc <= sh_out;
            r_cnt <= r_cnt - AMT_W'(1);
            if (w_last) begin
                r_result <= sh_out;
            end
        end
    end

    // Outside SHIFT the control is 00, so the shifter just passes acc through.
    assign sh_in   = r_acc;
    assign sh_ctrl = (r_state == S_SHIFT) ? r_op : 2'b00;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign result  = r_result;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       op;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] sh_in;
    logic [1:0]       sh_ctrl;
    logic [WIDTH-1:0] sh_out;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_data (in_data),
        .op      (op),
        .amount  (amount),
        .sh_in   (sh_in),
        .sh_ctrl (sh_ctrl),
        .sh_out  (sh_out),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    // Single-step shifter model
    always_comb begin
        case (sh_ctrl)
            2'b01:   sh_out = {sh_in[WIDTH-2:0], 1'b0};
            2'b10:   sh_out = {1'b0, sh_in[WIDTH-1:1]};
            2'b11:   sh_out = {sh_in[WIDTH-1], sh_in[WIDTH-1:1]};
            default: sh_out = sh_in;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and watch a bounded window of amt+4 cycles.
    // Cycle k is the k-th falling edge after the accepting rising edge.
    task automatic run_op(
        input  logic [WIDTH-1:0] d,
        input  logic [1:0]       o,
        input  logic [AMT_W-1:0] a,
        output int               done_cyc,
        output int               done_cnt,
        output int               busy_cyc,
        output int               ctrl_nz
    );
        done_cyc = -1;
        done_cnt = 0;
        busy_cyc = 0;
        ctrl_nz  = 0;
        @(negedge clk);
        start   = 1'b1;
        in_data = d;
        op      = o;
        amount  = a;
        for (int cyc = 1; cyc <= int'(a) + 4; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (busy) busy_cyc++;
            if (sh_ctrl != 2'b00) ctrl_nz++;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        in_data = '0;
        op      = 2'b00;
        amount  = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (sh_in !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_sh_in: got %h want 0000", sh_in);
        end
        n_checks++;
        if (sh_ctrl !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_sh_ctrl: got %b want 00", sh_ctrl);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_done: got %b%b want 00", busy, done);
        end
        n_checks++;
        if (result !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_result: got %h want 0000", result);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // LSL by 3. A start pulse with 0xFFFF arrives mid-operation and must be ignored.
    task automatic test_lsl_busy_ignore();
        int done_cyc;
        int done_cnt;
        int ctrl_cyc;
        int acc1;
        done_cyc = -1;
        done_cnt = 0;
        ctrl_cyc = 0;
        acc1     = -1;
        @(negedge clk);
        start   = 1'b1;
        in_data = 16'h0001;
        op      = 2'b01;
        amount  = 4'd3;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                acc1  = int'(sh_in);
            end
            if (cyc == 2) begin
                start   = 1'b1;
                in_data = 16'hFFFF;
            end
            if (cyc == 3) start = 1'b0;
            if (sh_ctrl == 2'b01) ctrl_cyc++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        n_checks++;
        if (acc1 != 1) begin
            n_fail++;
            $display("FAIL lsl_sh_in_first: got %0d want 1", acc1);
        end
        n_checks++;
        if (ctrl_cyc != 3) begin
            n_fail++;
            $display("FAIL lsl_ctrl_cycles: got %0d want 3", ctrl_cyc);
        end
        n_checks++;
        if (done_cyc != 4) begin
            n_fail++;
            $display("FAIL lsl_done_cycle: got %0d want 4", done_cyc);
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL lsl_done_count: got %0d want 1", done_cnt);
        end
        n_checks++;
        if (result !== 16'h0008) begin
            n_fail++;
            $display("FAIL lsl_result: got %h want 0008", result);
        end
    endtask

    task automatic test_lsr();
        int dc;
        int dn;
        int bc;
        int cn;
        run_op(16'h8000, 2'b10, 4'd4, dc, dn, bc, cn);
        n_checks++;
        if (result !== 16'h0800) begin
            n_fail++;
            $display("FAIL lsr_result: got %h want 0800", result);
        end
        n_checks++;
        if (bc != 5) begin
            n_fail++;
            $display("FAIL lsr_busy_cycles: got %0d want 5", bc);
        end
        n_checks++;
        if (dc != 5 || dn != 1) begin
            n_fail++;
            $display("FAIL lsr_done: got cycle %0d count %0d want cycle 5 count 1", dc, dn);
        end
    endtask

    task automatic test_asr_max();
        int dc;
        int dn;
        int bc;
        int cn;
        run_op(16'h8000, 2'b11, 4'd15, dc, dn, bc, cn);
        n_checks++;
        if (result !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL asr_neg_result: got %h want ffff", result);
        end
        n_checks++;
        if (dc != 16 || cn != 15) begin
            n_fail++;
            $display("FAIL asr_neg_timing: got done %0d ctrl %0d want 16 15", dc, cn);
        end
        run_op(16'h4000, 2'b11, 4'd15, dc, dn, bc, cn);
        n_checks++;
        if (result !== 16'h0000) begin
            n_fail++;
            $display("FAIL asr_pos_result: got %h want 0000", result);
        end
    endtask

    task automatic test_zero_none();
        int dc;
        int dn;
        int bc;
        int cn;
        run_op(16'h1234, 2'b11, 4'd0, dc, dn, bc, cn);
        n_checks++;
        if (result !== 16'h1234 || dc != 1 || cn != 0 || bc != 1) begin
            n_fail++;
            $display("FAIL zero_amount: got res %h done %0d ctrl %0d busy %0d want 1234 1 0 1",
                     result, dc, cn, bc);
        end
        // Clear result so the next check cannot pass on a stale value.
        run_op(16'h0001, 2'b01, 4'd1, dc, dn, bc, cn);
        run_op(16'h1234, 2'b00, 4'd7, dc, dn, bc, cn);
        n_checks++;
        if (result !== 16'h1234 || dc != 1 || cn != 0) begin
            n_fail++;
            $display("FAIL op_none: got res %h done %0d ctrl %0d want 1234 1 0", result, dc, cn);
        end
    endtask

    // Start held high: accepted at E0, ignored during SHIFT/DONE, then accepted again
    // on the IDLE edge E4.
    task automatic test_start_held();
        int dcnt;
        int busy4;
        int done6;
        logic [WIDTH-1:0] res3;
        dcnt  = 0;
        busy4 = -1;
        done6 = -1;
        res3  = '0;
        @(negedge clk);
        start   = 1'b1;
        in_data = 16'h0005;
        op      = 2'b01;
        amount  = 4'd2;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                in_data = 16'h0100;
                op      = 2'b10;
                amount  = 4'd1;
            end
            if (cyc == 3) res3 = result;
            if (cyc == 4) busy4 = int'(busy);
            if (cyc == 5) start = 1'b0;
            if (cyc == 6) done6 = int'(done);
            if (done) dcnt++;
        end
        n_checks++;
        if (res3 !== 16'h0014) begin
            n_fail++;
            $display("FAIL held_first_result: got %h want 0014", res3);
        end
        n_checks++;
        if (busy4 != 0) begin
            n_fail++;
            $display("FAIL held_idle_gap: busy got %0d want 0", busy4);
        end
        n_checks++;
        if (done6 != 1 || dcnt != 2 || result !== 16'h0080) begin
            n_fail++;
            $display("FAIL held_second: got done6 %0d count %0d res %h want 1 2 0080",
                     done6, dcnt, result);
        end
    endtask

    task automatic test_reset_mid_op();
        int dcnt;
        int dc;
        int dn;
        int bc;
        int cn;
        logic [WIDTH-1:0] acc5;
        dcnt = 0;
        acc5 = '0;
        @(negedge clk);
        start   = 1'b1;
        in_data = 16'h0001;
        op      = 2'b01;
        amount  = 4'd10;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (cyc == 5) acc5 = sh_in;
        end
        n_checks++;
        if (acc5 !== 16'h0010) begin
            n_fail++;
            $display("FAIL midop_acc_before_reset: got %h want 0010", acc5);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (sh_in !== 16'h0000 || sh_ctrl !== 2'b00 || busy !== 1'b0 ||
            done !== 1'b0 || result !== 16'h0000) begin
            n_fail++;
            $display("FAIL midop_async_reset: got sh_in %h ctrl %b busy %b done %b res %h want all 0",
                     sh_in, sh_ctrl, busy, done, result);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        n_checks++;
        if (dcnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_no_done: got done count %0d busy %b want 0 0", dcnt, busy);
        end
        run_op(16'h0003, 2'b01, 4'd2, dc, dn, bc, cn);
        n_checks++;
        if (result !== 16'h000C || dc != 3 || dn != 1) begin
            n_fail++;
            $display("FAIL midop_next_op: got res %h done %0d count %0d want 000c 3 1",
                     result, dc, dn);
        end
    endtask

    initial begin
        test_reset();
        test_lsl_busy_ignore();
        test_lsr();
        test_asr_max();
        test_zero_none();
        test_start_held();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: guarantees termination even if the clocking or tasks stall.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
